// File: rtl/nn_tile_engine.sv
// nn_tile_engine: self-sequencing matrix-vector engine.
// One FSM walks cfg_tiles tiles. For each tile it streams K weight rows and K
// input elements out of 1-cycle-latency BRAMs. N_MACS lanes accumulate w*x.
// The finished tile is then presented on a valid/ready result port, with an
// optional ReLU applied on the way out.
module nn_tile_engine #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int N_MACS    = 4,
    parameter int K_MAX     = 16,
    parameter int MEM_DEPTH = 256,
    parameter int TILE_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
    input  logic [TILE_W-1:0]            cfg_tiles,
    input  logic [$clog2(MEM_DEPTH)-1:0] cfg_w_base,
    input  logic [$clog2(MEM_DEPTH)-1:0] cfg_in_base,
    input  logic                         cfg_relu,
    output logic [$clog2(MEM_DEPTH)-1:0] w_bram_addr,
    output logic                         w_bram_en,
    input  logic [N_MACS*DATA_W-1:0]     w_bram_dout,
    output logic [$clog2(MEM_DEPTH)-1:0] in_bram_addr,
    output logic                         in_bram_en,
    input  logic [DATA_W-1:0]            in_bram_dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_MACS*ACC_W-1:0]      out_data,
    output logic [TILE_W-1:0]            out_tile,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int KW = $clog2(K_MAX+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched job configuration
    logic [KW-1:0]     cfg_k_q;
    logic [TILE_W-1:0] cfg_tiles_q;
    logic [AW-1:0]     cfg_w_base_q;
    logic [AW-1:0]     cfg_in_base_q;
    logic              cfg_relu_q;

    // Sequencing counters; w_off_q tracks tile*K modulo the BRAM depth
    logic [KW-1:0]     k_q;
    logic [TILE_W-1:0] tile_q;
    logic [AW-1:0]     w_off_q;

    // FSM strobes
    logic fetch, load_cfg, clr_acc, tile_adv, last_k, last_tile;

    // MAC datapath
    logic                     mac_vld_q;
    logic signed [ACC_W-1:0]  acc_q    [N_MACS];
    logic signed [ACC_W-1:0]  prod_ext [N_MACS];
    logic signed [DATA_W-1:0] x_s;

    // Negative results are clamped to zero when ReLU is enabled
    function automatic logic signed [ACC_W-1:0] relu_clamp(
        input logic signed [ACC_W-1:0] a,
        input logic                    en
    );
        if (en && a[ACC_W-1]) return '0;
        return a;
    endfunction

    assign last_k    = (k_q == cfg_k_q - KW'(1));
    assign last_tile = (tile_q == cfg_tiles_q - TILE_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_d   = state_q;
        fetch     = 1'b0;
        load_cfg  = 1'b0;
        clr_acc   = 1'b0;
        tile_adv  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    clr_acc  = 1'b1;
                    if (cfg_tiles == '0)  state_d = S_DONE;
                    else if (cfg_k == '0) state_d = S_FLUSH;
                    else                  state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch = 1'b1;
                if (last_k) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clr_acc = 1'b1;
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        tile_adv = 1'b1;
                        state_d  = (cfg_k_q == '0) ? S_FLUSH : S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration latch and k / tile counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_k_q       <= '0;
            cfg_tiles_q   <= '0;
            cfg_w_base_q  <= '0;
            cfg_in_base_q <= '0;
            cfg_relu_q    <= 1'b0;
            k_q           <= '0;
            tile_q        <= '0;
            w_off_q       <= '0;
        end else if (load_cfg) begin
            cfg_k_q       <= cfg_k;
            cfg_tiles_q   <= cfg_tiles;
            cfg_w_base_q  <= cfg_w_base;
            cfg_in_base_q <= cfg_in_base;
            cfg_relu_q    <= cfg_relu;
            k_q           <= '0;
            tile_q        <= '0;
            w_off_q       <= '0;
        end else if (tile_adv) begin
            k_q     <= '0;
            tile_q  <= tile_q + TILE_W'(1);
            w_off_q <= w_off_q + AW'(cfg_k_q);
        end else if (fetch) begin
            k_q <= k_q + KW'(1);
        end
    end

    // BRAM request side: addresses wrap naturally at AW bits
    assign w_bram_en    = fetch;
    assign in_bram_en   = fetch;
    assign w_bram_addr  = fetch ? (cfg_w_base_q + w_off_q + AW'(k_q)) : '0;
    assign in_bram_addr = fetch ? (cfg_in_base_q + AW'(k_q)) : '0;
    assign busy         = (state_q != S_IDLE);

    assign x_s = in_bram_dout;

    // Full-precision signed product per lane, sign-extended to accumulator width
    for (genvar g = 0; g < N_MACS; g++) begin : g_lane
        logic signed [DATA_W-1:0]   w_s;
        logic signed [2*DATA_W-1:0] prod;
        assign w_s         = w_bram_dout[g*DATA_W +: DATA_W];
        assign prod        = (2*DATA_W)'(w_s) * (2*DATA_W)'(x_s);
        assign prod_ext[g] = ACC_W'(prod);
    end

    // Accumulate one cycle after each BRAM read; wraps modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_vld_q <= 1'b0;
            for (int i = 0; i < N_MACS; i++) acc_q[i] <= '0;
        end else begin
            mac_vld_q <= fetch;
            for (int i = 0; i < N_MACS; i++) begin
                if (clr_acc)        acc_q[i] <= '0;
                else if (mac_vld_q) acc_q[i] <= acc_q[i] + prod_ext[i];
            end
        end
    end

    // Result port: driven only while a tile is being offered
    always_comb begin
        out_data = '0;
        out_tile = '0;
        if (out_valid) begin
            out_tile = tile_q;
            for (int i = 0; i < N_MACS; i++)
                out_data[i*ACC_W +: ACC_W] = relu_clamp(acc_q[i], cfg_relu_q);
        end
    end

endmodule

// File: tb/tb_nn_tile_engine.sv
// Testbench for nn_tile_engine: BRAM models, directed jobs, random jobs,
// and a reference model that computes each tile from plain sums of products.
module tb_nn_tile_engine;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 32;
    localparam int N_MACS    = 4;
    localparam int K_MAX     = 16;
    localparam int MEM_DEPTH = 256;
    localparam int TILE_W    = 4;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int KW        = $clog2(K_MAX+1);
    localparam int OW        = N_MACS*ACC_W;

    logic                     clk = 1'b0;
    logic                     rst, start, cfg_relu, out_ready;
    logic [KW-1:0]            cfg_k;
    logic [TILE_W-1:0]        cfg_tiles;
    logic [AW-1:0]            cfg_w_base, cfg_in_base;
    logic [AW-1:0]            w_bram_addr, in_bram_addr;
    logic                     w_bram_en, in_bram_en;
    logic [N_MACS*DATA_W-1:0] w_bram_dout;
    logic [DATA_W-1:0]        in_bram_dout;
    logic                     out_valid, busy, done;
    logic [OW-1:0]            out_data;
    logic [TILE_W-1:0]        out_tile;

    logic [N_MACS*DATA_W-1:0] w_mem  [MEM_DEPTH];
    logic [DATA_W-1:0]        in_mem [MEM_DEPTH];

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [OW-1:0] last_data;

    nn_tile_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .N_MACS(N_MACS),
        .K_MAX(K_MAX), .MEM_DEPTH(MEM_DEPTH), .TILE_W(TILE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
        .cfg_w_base(cfg_w_base), .cfg_in_base(cfg_in_base), .cfg_relu(cfg_relu),
        .w_bram_addr(w_bram_addr), .w_bram_en(w_bram_en), .w_bram_dout(w_bram_dout),
        .in_bram_addr(in_bram_addr), .in_bram_en(in_bram_en), .in_bram_dout(in_bram_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tile(out_tile),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM models, one cycle of latency
    always @(posedge clk) begin
        if (w_bram_en)  w_bram_dout  <= w_mem[w_bram_addr];
        if (in_bram_en) in_bram_dout <= in_mem[in_bram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: y_i = sum_k W[tile*K+k][i] * x[k], wrapped to ACC_W, optional ReLU
    function automatic logic [OW-1:0] model_tile(input int t, input int k, input int wb,
                                                 input int ib, input bit relu);
        logic [OW-1:0]            r;
        logic [N_MACS*DATA_W-1:0] wr;
        logic signed [DATA_W-1:0] w, x;
        logic signed [ACC_W-1:0]  a;
        longint                   s;
        r = '0;
        for (int i = 0; i < N_MACS; i++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) begin
                wr = w_mem[(wb + t*k + kk) % MEM_DEPTH];
                w  = wr[i*DATA_W +: DATA_W];
                x  = in_mem[(ib + kk) % MEM_DEPTH];
                s  = s + longint'(w) * longint'(x);
            end
            a = s[ACC_W-1:0];
            if (relu && a < 0) a = '0;
            r[i*ACC_W +: ACC_W] = a;
        end
        return r;
    endfunction

    // Run one complete job; stall < 0 picks a random 0..3 cycle stall per tile
    task automatic run_job(input int k, input int t, input int wb, input int ib,
                           input bit relu, input int stall);
        int            en_idx, tiles_seen, last_hs, stall_cnt, st;
        bit            in_out, got_done;
        logic [OW-1:0] expd;
        en_idx = 0; tiles_seen = 0; last_hs = 0; stall_cnt = 0;
        in_out = 1'b0; got_done = 1'b0; expd = '0;
        st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        cfg_k = KW'(k); cfg_tiles = TILE_W'(t);
        cfg_w_base = AW'(wb); cfg_in_base = AW'(ib); cfg_relu = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !got_done; cyc++) begin
            chk("busy", OW'(busy), OW'(1));
            if (w_bram_en) begin
                if (k == 0) begin
                    chk("en_with_k0", OW'(1), OW'(0));
                end else begin
                    chk("w_addr", OW'(w_bram_addr),
                        OW'((wb + (en_idx / k) * k + en_idx % k) % MEM_DEPTH));
                    chk("in_en", OW'(in_bram_en), OW'(1));
                    chk("in_addr", OW'(in_bram_addr), OW'((ib + en_idx % k) % MEM_DEPTH));
                end
                en_idx++;
            end
            if (out_valid) begin
                if (!in_out) begin
                    in_out    = 1'b1;
                    stall_cnt = 0;
                    expd      = model_tile(tiles_seen, k, wb, ib, relu);
                    chk("vld_cycle", OW'(cyc), OW'(last_hs + k + 2));
                    chk("out_tile", OW'(out_tile), OW'(tiles_seen));
                    chk("out_data", out_data, expd);
                end else begin
                    chk("hold_data", out_data, expd);
                    chk("hold_tile", OW'(out_tile), OW'(tiles_seen));
                    chk("hold_no_en", OW'(w_bram_en | in_bram_en), OW'(0));
                end
                if (stall_cnt < st) begin
                    stall_cnt++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    last_hs   = cyc;
                    last_data = out_data;
                    tiles_seen++;
                    in_out    = 1'b0;
                    st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                end
            end else begin
                if (in_out) begin
                    chk("valid_dropped", OW'(1), OW'(0));
                    in_out = 1'b0;
                end
                out_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                got_done = 1'b1;
                start    = 1'b0;
                chk("done_cycle", OW'(cyc), OW'((t == 0) ? 1 : last_hs + 1));
                chk("tiles_out", OW'(tiles_seen), OW'(t));
            end else begin
                // stray start and config churn while busy must be ignored
                start       = ($urandom_range(0, 3) == 0);
                cfg_k       = KW'($urandom_range(0, K_MAX));
                cfg_tiles   = TILE_W'($urandom);
                cfg_w_base  = AW'($urandom);
                cfg_in_base = AW'($urandom);
                cfg_relu    = 1'($urandom);
            end
            tick();
        end
        if (!got_done) chk("job_timeout", OW'(0), OW'(1));
        chk("en_count", OW'(en_idx), OW'(t * k));
        chk("idle_busy", OW'(busy), OW'(0));
        chk("idle_done", OW'(done), OW'(0));
    endtask

    initial begin
        int   seen;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; cfg_relu = 1'b0;
        cfg_k = '0; cfg_tiles = '0; cfg_w_base = '0; cfg_in_base = '0;
        w_bram_dout = '0; in_bram_dout = '0;
        for (int a = 0; a < MEM_DEPTH; a++) begin
            w_mem[a]  = {$urandom, $urandom};
            in_mem[a] = DATA_W'($urandom);
        end
        tick();
        tick();
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_done", OW'(done), OW'(0));
        chk("rst_valid", OW'(out_valid), OW'(0));
        chk("rst_w_en", OW'(w_bram_en), OW'(0));
        chk("rst_out_data", out_data, OW'(0));
        rst = 1'b0;
        tick();

        // K=4, T=1: lanes weigh 1..4, x = 1..4
        for (int kk = 0; kk < 4; kk++) begin
            w_mem[kk]       = {16'd4, 16'd3, 16'd2, 16'd1};
            in_mem[100 + kk] = DATA_W'(kk + 1);
        end
        run_job(4, 1, 0, 100, 1'b0, 0);
        chk("basic_result", last_data, {32'd40, 32'd30, 32'd20, 32'd10});

        // K=3, T=2, ReLU: tile1 weights -1 against x=5 clamp to zero; 10-cycle stall
        for (int kk = 0; kk < 3; kk++) begin
            w_mem[20 + kk]  = {4{16'd2}};
            w_mem[23 + kk]  = {4{16'hFFFF}};
            in_mem[50 + kk] = 16'd5;
        end
        run_job(3, 2, 20, 50, 1'b1, 10);
        chk("relu_tile1", last_data, OW'(0));

        // Weight address wraps past the top of the BRAM; then an empty job
        run_job(4, 1, 254, 10, 1'b0, -1);
        run_job(4, 0, 0, 0, 1'b0, 0);

        // 0x7FFF*0x7FFF summed 16 times wraps the 32-bit accumulator
        for (int kk = 0; kk < 16; kk++) begin
            w_mem[128 + kk]  = {4{16'h7FFF}};
            in_mem[200 + kk] = 16'h7FFF;
        end
        run_job(16, 1, 128, 200, 1'b0, 0);
        chk("wrap_result", last_data, {4{32'hFFF00010}});

        // Second start mid-job is ignored, then reset aborts the job
        cfg_k = KW'(8); cfg_tiles = TILE_W'(2); cfg_w_base = AW'(40);
        cfg_in_base = AW'(0); cfg_relu = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        cfg_w_base = AW'(90);
        tick();
        start = 1'b0;
        chk("restart_ignored", OW'(w_bram_addr), OW'(42));
        rst = 1'b1;
        tick();
        chk("abort_busy", OW'(busy), OW'(0));
        chk("abort_done", OW'(done), OW'(0));
        chk("abort_valid", OW'(out_valid), OW'(0));
        chk("abort_en", OW'(w_bram_en | in_bram_en), OW'(0));
        chk("abort_addr", OW'({w_bram_addr, in_bram_addr}), OW'(0));
        chk("abort_data", out_data, OW'(0));
        chk("abort_tile", OW'(out_tile), OW'(0));
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy || out_valid) seen++;
            tick();
        end
        chk("abort_quiet", OW'(seen), OW'(0));

        // Random jobs, back-to-back, against the reference model
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, K_MAX)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(0, MEM_DEPTH - 1)),
                    1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
